// File: rtl/pulse_sync_pkg.sv
// Shared definitions for the pulse req/ack handshake transmitter and its matching receiver.
package pulse_sync_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACK_LO = 2'd2
    } hs_state_e;

    function automatic int sync_stages(input int delay_2);
        return 2 + delay_2;
    endfunction

endpackage

// File: rtl/pulse_hs_tx_if.sv
// Source-side pulse input, four-phase req/ack pair and status of the pulse handshake transmitter.
interface pulse_hs_tx_if
    import pulse_sync_pkg::*;
#(
    parameter int CNT_W = 4
);
    // Four-phase protocol: hs_req rises to offer one event; the receiver raises hs_ack
    // once taken; hs_req falls only after hs_ack is seen high (synchronized); the receiver
    // then drops hs_ack, and the transfer is complete once the synchronized hs_ack is low.
    logic             src_pulse;
    logic             hs_req;
    logic             hs_ack;
    logic [CNT_W-1:0] pend_cnt;
    logic             busy;
    logic             done_pulse;
    logic             ovf_pulse;
    hs_state_e        state_dbg;

    modport master (
        input  src_pulse,
        input  hs_ack,
        output hs_req,
        output pend_cnt,
        output busy,
        output done_pulse,
        output ovf_pulse,
        output state_dbg
    );

    modport slave (
        output src_pulse,
        output hs_ack,
        input  hs_req,
        input  pend_cnt,
        input  busy,
        input  done_pulse,
        input  ovf_pulse,
        input  state_dbg
    );

endinterface

// File: rtl/sync_rst_h.sv
// Multi-flop synchronizer with asynchronous active-high reset to a configurable default.
module sync_rst_h
    import pulse_sync_pkg::*;
#(
    parameter int   D_WIDTH      = 1,
    parameter int   DELAY_2      = 1,
    parameter logic DATA_DEFAULT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] d,
    output logic [D_WIDTH-1:0] q
);

    localparam int SYNC = sync_stages(DELAY_2);

    logic [D_WIDTH-1:0] stage_q [SYNC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++) begin
                stage_q[i] <= {D_WIDTH{DATA_DEFAULT}};
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC-1];

endmodule

// File: rtl/pulse_hs_tx.sv
// Pulse handshake transmitter: queues source pulses in a saturating counter and issues
// one four-phase request per pulse, retired on the synchronized acknowledge.
module pulse_hs_tx
    import pulse_sync_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int DELAY_2 = 1
) (
    input  logic          src_clk,
    input  logic          src_rst,
    pulse_hs_tx_if.master hs
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hs_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hs_req_q;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             ack_s;
    logic             inc, dec;

    sync_rst_h #(
        .D_WIDTH      (1),
        .DELAY_2      (DELAY_2),
        .DATA_DEFAULT (1'b0)
    ) u_ack_sync (
        .clk (src_clk),
        .rst (src_rst),
        .d   (hs.hs_ack),
        .q   (ack_s)
    );

    // A pulse and a retirement on the same edge cancel; a pulse at saturation is lost.
    always_comb begin
        inc   = hs.src_pulse;
        dec   = (state_q == REQ) && ack_s;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec && !inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // IDLE also waits for a low ack_s so a request can never start against a stale ack.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if ((cnt_q != '0) && !ack_s) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_d = ACK_LO;
                end
            end
            ACK_LO: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hs_req_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hs_req_q <= (state_d == REQ);
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign hs.hs_req     = hs_req_q;
    assign hs.pend_cnt   = cnt_q;
    assign hs.busy       = (state_q != IDLE) || (cnt_q != '0);
    assign hs.done_pulse = done_q;
    assign hs.ovf_pulse  = ovf_q;
    assign hs.state_dbg  = state_q;

endmodule
